// File: rtl/i2s_pkg.sv
// Shared constants and the framing state type for the I2S receive path.
package i2s_pkg;

    // Default number of bits captured per channel slot.
    localparam int I2S_DEFAULT_WIDTH = 16;

    // Channel encoding, which is the LRCLK level of the slot.
    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    // Framing states:
    //   ST_IDLE  - receiver disabled
    //   ST_SYNC  - waiting for the first LRCLK edge
    //   ST_SHIFT - capturing slots
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } i2s_state_e;

endpackage : i2s_pkg

// File: rtl/i2s_pin_sync.sv
// Per-pin conditioning for the I2S receiver. The pin passes through a
// two-flop synchronizer and then one history flop.
// 'level' is the synchronized pin value.
// 'rise' flags a 0->1 transition of that value.
module i2s_pin_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    // Next-state for the synchronizer chain and the history flop.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~hist_q;

endmodule : i2s_pin_sync

// File: rtl/i2s_rx.sv
// I2S receiver. It oversamples SCLK/LRCLK/SDATA on the system clock and
// delivers stereo sample pairs with a one-cycle sample_valid strobe.
// Optional feature: define I2S_RX_ERR_EN to add the frame_err and err_count
// outputs, which report short slots.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             sample_valid
`ifdef I2S_RX_ERR_EN
    ,
    output logic             frame_err,
    output logic [7:0]       err_count
`endif
);

    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    BITS_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]    BITS_LAST = CW'(WIDTH - 1);

    // Conditioned pins. All three come from the same synchronizer stage,
    // so LRCLK and SDATA line up with the SCLK rise that samples them.
    logic sclk_lvl_unused, sclk_rise;
    logic lr_lvl,          lr_rise_unused;
    logic sd_lvl,          sd_rise_unused;

    i2s_pin_sync u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sclk),
        .level   (sclk_lvl_unused),
        .rise    (sclk_rise)
    );

    i2s_pin_sync u_sync_lrclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (lrclk),
        .level   (lr_lvl),
        .rise    (lr_rise_unused)
    );

    i2s_pin_sync u_sync_sdata (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sdata),
        .level   (sd_lvl),
        .rise    (sd_rise_unused)
    );

    i2s_state_e       state_q,        state_d;
    logic             prev_lr_q,      prev_lr_d;
    logic             have_prev_q,    have_prev_d;
    logic             chan_q,         chan_d;
    logic [CW-1:0]    bitcnt_q,       bitcnt_d;
    logic [WIDTH-1:0] shift_q,        shift_d;
    logic             done_q,         done_d;
    logic [WIDTH-1:0] left_hold_q,    left_hold_d;
    logic             left_ok_q,      left_ok_d;
    logic [WIDTH-1:0] left_chan_q,    left_chan_d;
    logic [WIDTH-1:0] right_chan_q,   right_chan_d;
    logic             sample_valid_q, sample_valid_d;
`ifdef I2S_RX_ERR_EN
    logic             frame_err_q,    frame_err_d;
    logic [7:0]       err_count_q,    err_count_d;
`endif

    logic lr_changed;
    logic slot_short;

    // The LRCLK edge is judged against the level seen at the previous SCLK
    // rise. A remembered level is therefore required before SYNC can lock.
    assign lr_changed = sclk_rise && have_prev_q && (lr_lvl != prev_lr_q);
    assign slot_short = (state_q == ST_SHIFT) && (bitcnt_q != BITS_FULL);

    // Framing, shifting and output hand-off.
    always_comb begin
        state_d        = state_q;
        prev_lr_d      = prev_lr_q;
        have_prev_d    = have_prev_q;
        chan_d         = chan_q;
        bitcnt_d       = bitcnt_q;
        shift_d        = shift_q;
        done_d         = 1'b0;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        left_chan_d    = left_chan_q;
        right_chan_d   = right_chan_q;
        sample_valid_d = 1'b0;
`ifdef I2S_RX_ERR_EN
        frame_err_d    = frame_err_q;
        err_count_d    = err_count_q;
`endif

        if (!enable) begin
            // Disabled: drop all framing context; the visible samples are held.
            state_d     = ST_IDLE;
            have_prev_d = 1'b0;
            bitcnt_d    = '0;
            shift_d     = '0;
            left_hold_d = '0;
            left_ok_d   = 1'b0;
`ifdef I2S_RX_ERR_EN
            frame_err_d = 1'b0;
            err_count_d = '0;
`endif
        end else begin
            // A slot that completed on the previous cycle is handed on one
            // edge after its final shift.
            if (done_q) begin
                if (chan_q == I2S_LEFT) begin
                    left_hold_d = shift_q;
                    left_ok_d   = 1'b1;
                end else if (left_ok_q) begin
                    left_chan_d    = left_hold_q;
                    right_chan_d   = shift_q;
                    sample_valid_d = 1'b1;
                    left_ok_d      = 1'b0;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC, ST_SHIFT: begin
                    if (lr_changed) begin
                        // The bit sampled here is the previous slot's LSB.
                        if (slot_short) begin
                            if (chan_q == I2S_LEFT) begin
                                left_ok_d = 1'b0;
                            end
`ifdef I2S_RX_ERR_EN
                            frame_err_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
`endif
                        end
                        state_d  = ST_SHIFT;
                        chan_d   = lr_lvl;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end else if (sclk_rise && slot_short) begin
                        shift_d  = {shift_q[WIDTH-2:0], sd_lvl};
                        bitcnt_d = bitcnt_q + CW'(1);
                        done_d   = (bitcnt_q == BITS_LAST);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (sclk_rise) begin
                prev_lr_d   = lr_lvl;
                have_prev_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            prev_lr_q      <= 1'b0;
            have_prev_q    <= 1'b0;
            chan_q         <= I2S_LEFT;
            bitcnt_q       <= '0;
            shift_q        <= '0;
            done_q         <= 1'b0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            left_chan_q    <= '0;
            right_chan_q   <= '0;
            sample_valid_q <= 1'b0;
`ifdef I2S_RX_ERR_EN
            frame_err_q    <= 1'b0;
            err_count_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            prev_lr_q      <= prev_lr_d;
            have_prev_q    <= have_prev_d;
            chan_q         <= chan_d;
            bitcnt_q       <= bitcnt_d;
            shift_q        <= shift_d;
            done_q         <= done_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            left_chan_q    <= left_chan_d;
            right_chan_q   <= right_chan_d;
            sample_valid_q <= sample_valid_d;
`ifdef I2S_RX_ERR_EN
            frame_err_q    <= frame_err_d;
            err_count_q    <= err_count_d;
`endif
        end
    end

    assign left_chan    = left_chan_q;
    assign right_chan   = right_chan_q;
    assign sample_valid = sample_valid_q;
`ifdef I2S_RX_ERR_EN
    assign frame_err    = frame_err_q;
    assign err_count    = err_count_q;
`endif

endmodule : i2s_rx

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx. A behavioural I2S master drives the pins.
// Received pairs are collected from sample_valid.
module tb_i2s_rx;

    localparam int W = 16;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          sclk;
    logic          lrclk;
    logic          sdata;
    logic [W-1:0]  left_chan;
    logic [W-1:0]  right_chan;
    logic          sample_valid;
`ifdef I2S_RX_ERR_EN
    logic          frame_err;
    logic [7:0]    err_count;
`endif

    int    n_assert = 0;
    int    n_fail   = 0;
    int    half_ns;
    int    wide_err = 0;
    logic  sv_prev  = 1'b0;
    logic  carry;
    pair_t got_q[$];
    pair_t exp_q[$];

    i2s_rx #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid)
`ifdef I2S_RX_ERR_EN
        ,
        .frame_err    (frame_err),
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Collect each strobed pair, and flag any strobe longer than one cycle.
    always @(negedge clk) begin
        if (sample_valid) got_q.push_back({left_chan, right_chan});
        if (sample_valid && sv_prev) wide_err++;
        sv_prev = sample_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends one slot of n SCLK cycles. The first cycle carries the previous
    // slot's LSB, and the bits of 'word' follow MSB first.
    task automatic send_slot(input logic ch, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            sclk  = 1'b0;
            lrclk = ch;
            sdata = (i == 0) ? carry : word[32 - i];
            #(half_ns);
            sclk = 1'b1;
            #(half_ns);
        end
        carry = word[32 - n];
    endtask

    task automatic send_frame16(input logic [15:0] l, input logic [15:0] r, input int n);
        send_slot(1'b0, {l, 16'h0000}, n);
        send_slot(1'b1, {r, 16'h0000}, n);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic expect_pairs(input string tag, input int cnt, input logic [15:0] l, input logic [15:0] r);
        check({tag, "_count"}, got_q.size(), cnt);
        foreach (got_q[i]) begin
            check({tag, "_left"},  got_q[i].l, l);
            check({tag, "_right"}, got_q[i].r, r);
        end
        got_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        sclk    = 1'b0;
        lrclk   = 1'b0;
        sdata   = 1'b0;
        carry   = 1'b0;
        half_ns = 30;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_left",  left_chan,    '0);
        check("rst_right", right_chan,   '0);
        check("rst_valid", sample_valid, 1'b0);
`ifdef I2S_RX_ERR_EN
        check("rst_ferr",  frame_err,    1'b0);
        check("rst_ecnt",  err_count,    8'd0);
`endif
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) @(posedge clk);

        // Loopback with 32-bit slots. The first frame only locks the framing.
        repeat (4) send_frame16(16'h8001, 16'h7FFE, 32);
        settle();
        expect_pairs("loop", 3, 16'h8001, 16'h7FFE);
        check("loop_hold_left", left_chan, 16'h8001);

        // Reset after 7 right-slot data bits.
        send_slot(1'b0, {16'hA5A5, 16'h0000}, 32);
        send_slot(1'b1, {16'h5A5A, 16'h0000}, 8);
        reset_n = 1'b0;
        sclk    = 1'b0;
        #1;
        check("mid_rst_left",  left_chan,    '0);
        check("mid_rst_right", right_chan,   '0);
        check("mid_rst_valid", sample_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        send_frame16(16'h1111, 16'h2222, 32);
        send_frame16(16'h3333, 16'h4444, 32);
        settle();
        expect_pairs("after_rst", 1, 16'h3333, 16'h4444);

        // 32-bit words truncated to the upper 16 bits.
        repeat (3) begin
            send_slot(1'b0, 32'hDEADBEEF, 32);
            send_slot(1'b1, 32'h12345678, 32);
        end
        settle();
        expect_pairs("w32", 3, 16'hDEAD, 16'h1234);

        // Short left slot (10 bits): that frame is dropped.
        send_slot(1'b0, {16'hBEEF, 16'h0000}, 11);
        send_slot(1'b1, {16'h0F0F, 16'h0000}, 32);
        send_frame16(16'hC001, 16'hC002, 32);
        settle();
        expect_pairs("short_l", 1, 16'hC001, 16'hC002);
`ifdef I2S_RX_ERR_EN
        check("short_ferr", frame_err, 1'b1);
        check("short_ecnt", err_count, 8'd1);
`endif

        // Full left, short right, then short left: the stored left must be lost.
        send_slot(1'b0, {16'h1357, 16'h0000}, 32);
        send_slot(1'b1, {16'h2468, 16'h0000}, 5);
        send_slot(1'b0, {16'h1111, 16'h0000}, 11);
        send_slot(1'b1, {16'h2222, 16'h0000}, 32);
        send_frame16(16'h7E57, 16'h0BAD, 32);
        settle();
        expect_pairs("short_lok", 1, 16'h7E57, 16'h0BAD);
`ifdef I2S_RX_ERR_EN
        check("short2_ecnt", err_count, 8'd3);
`endif

        // Disabled for 3 frames: outputs held, no strobes.
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef I2S_RX_ERR_EN
        check("dis_ferr", frame_err, 1'b0);
        check("dis_ecnt", err_count, 8'd0);
`endif
        repeat (3) send_frame16(16'h5555, 16'h6666, 32);
        settle();
        check("dis_pulses", got_q.size(), 0);
        check("dis_left",   left_chan,    16'h7E57);
        check("dis_right",  right_chan,   16'h0BAD);
        got_q.delete();
        enable = 1'b1;
        repeat (3) send_frame16(16'h9ABC, 16'hDEF0, 32);
        settle();
        expect_pairs("reenable", 2, 16'h9ABC, 16'hDEF0);

        // Minimum SCLK period (4 clk) with a random phase before each frame.
        half_ns = 20;
        for (int f = 0; f < 400; f++) begin
            pair_t p;
            p.l = 16'($urandom);
            p.r = 16'($urandom);
            exp_q.push_back(p);
            #($urandom_range(0, 9));
            send_frame16(p.l, p.r, 17);
        end
        settle();
        check("fast_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("fast_left",  got_q[i].l, exp_q[i].l);
            check("fast_right", got_q[i].r, exp_q[i].r);
        end
        got_q.delete();

        check("valid_width", wide_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_i2s_rx
